sseg_to_hex: RTL and testbench
==============================

# sseg_to_hex

Seven-segment display readback decoder: it observes the time-multiplexed, active-low anode and segment lines driven to a 4-digit LED display and recovers the displayed hex digits and decimal points. It sits beside the display driver and lets a bench, or an on-chip self-check, read what is actually on the display as hex values. Each digit is accepted only after its segment pattern has been stable for a programmable dwell. The block flags illegal patterns and pulses once per complete four-digit frame.

## Interface
- STABLE_CYCLES, 4: consecutive matching samples required before a digit is captured (min 1, max 255)
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- an  input  4  anode enables, active low; an[i]=0 selects digit i
- sseg  input  8  segments, active low; bit 7 = dp, bits 6..0 = a,b,c,d,e,f,g
- hex_out  output  16  captured digits; digit i in hex_out[4i+3:4i]
- dp_out  output  4  dp_out[i]=1 when digit i's dp was lit (sseg[7]=0) at capture
- valid  output  4  valid[i]=1 when digit i holds a legal capture
- err  output  4  err[i]=1 when the last capture of digit i was an illegal pattern
- frame_done  output  1  one-cycle pulse when all four digits have had a legal capture since the previous pulse

## Operation
- Input stage: every edge, an_q<=an and sseg_q<=sseg.
- same = (an==an_q) && (sseg==sseg_q).
- Stability counter cnt: 0 when !same; otherwise increments, saturating at STABLE_CYCLES.
- Capture event: same && cnt==STABLE_CYCLES-1. This fires exactly once per stable dwell. No recapture until the inputs change.
- Capture ignored (no output change) unless an_q has exactly one bit low. Patterns 1111, 0000, and multiple lows are ignored.
- Legal decode of sseg_q[6:0] (abcdefg):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F
- Legal capture on digit i:
  - hex_out nibble i <= decoded value
  - dp_out[i] <= ~sseg_q[7]
  - valid[i] <= 1, err[i] <= 0
  - seen[i] <= 1
- Illegal capture on digit i (any other pattern, including blank 1111111):
  - valid[i] <= 0, err[i] <= 1
  - hex_out nibble i and dp_out[i] hold their previous values
  - seen[i] unchanged
- Frame FSM, two states:
  - COLLECT: seen accumulates. When a legal capture makes seen==4'b1111, go to DONE.
  - DONE: lasts one cycle. frame_done=1, seen<=0, then return to COLLECT.
  - A capture arriving while in DONE is processed normally. It sets its seen bit after the clear, i.e. it counts toward the next frame.
- Reset (async, any time, including mid-dwell):
  - hex_out=0, dp_out=0, valid=0, err=0, frame_done=0
  - an_q=4'hF, sseg_q=8'hFF, cnt=0, seen=0, state COLLECT
  - After release, a full dwell is needed before the first capture.

## Timing
- Inputs change before edge E0 and then hold. an_q loads at E0 (cnt->0), inputs match at E1..E(S), and the capture updates outputs at edge E(S), where S=STABLE_CYCLES. The total is S+1 samples of constant input.
- A change at any edge before the capture restarts the count from 0.
- frame_done asserts on the edge after the completing capture edge and lasts exactly one cycle.
- All outputs are registered; there is no combinational input-to-output path.
- Inputs are same-domain signals. Asynchronous pins must be synchronised externally.

## Test plan
- Reset, then scan an=1110/1101/1011/0111 with sseg=0000110/0010010/1001111/0000001 (dp off), each held 8 cycles, S=4. Required: hex_out=16'h0123, valid=1111, err=0, dp_out=0, and exactly one frame_done, one cycle after digit 3's capture.
- Dwell exactly S samples (one short), then exactly S+1 samples. Required: no capture in the first case. In the second, capture occurs at edge E(S).
- Digit 2 shows 1111111, then later 0111000 with sseg[7]=0. Required: first valid[2]=0, err[2]=1, nibble unchanged; then nibble 2=F, dp_out[2]=1, valid[2]=1, err[2]=0.
- an=1100 or 1111 held 20 cycles. Required: no output change, no frame_done.
- Hold one pattern for 100 cycles. Required: a single capture; seen does not re-trigger frame_done without the other digits.
- Assert reset_n=0 mid-dwell and mid-frame (seen=0111). Required: all outputs 0 immediately; after release the next frame needs all four digits again.

Source files
------------

// File: rtl/sseg_to_hex.sv
// Seven-segment readback decoder: watches the multiplexed active-low anode/segment
// lines of a 4-digit display and recovers the shown hex digits, dp flags and frame completion.
module sseg_to_hex #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] hex_out,
  output logic [3:0]  dp_out,
  output logic [3:0]  valid,
  output logic [3:0]  err,
  output logic        frame_done
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        an_q;
  logic [7:0]        sseg_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       hex_q, hex_d;
  logic [3:0]        dp_q, dp_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0]        err_q, err_d;
  logic [3:0]        seen_q, seen_d;
  logic              fd_q, fd_d;

  logic              same_c;
  logic              capture_c;
  logic              sel_ok_c;
  logic [1:0]        sel_idx_c;
  logic              seg_legal_c;
  logic [3:0]        seg_val_c;

  // Input sample stage; reset to the "all dark" pattern so a full dwell is needed after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q   <= 4'hF;
      sseg_q <= 8'hFF;
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
    end
  end

  assign same_c    = (an == an_q) && (sseg == sseg_q);
  assign capture_c = same_c && (cnt_q == CNT_FIRE);

  // Exactly one anode low selects a digit; anything else is not a readable digit slot.
  always_comb begin
    sel_ok_c  = 1'b1;
    sel_idx_c = 2'd0;
    unique case (an_q)
      4'b1110: sel_idx_c = 2'd0;
      4'b1101: sel_idx_c = 2'd1;
      4'b1011: sel_idx_c = 2'd2;
      4'b0111: sel_idx_c = 2'd3;
      default: sel_ok_c  = 1'b0;
    endcase
  end

  // Active-low abcdefg pattern to hex value.
  always_comb begin
    seg_legal_c = 1'b1;
    seg_val_c   = 4'h0;
    unique case (sseg_q[6:0])
      7'b0000001: seg_val_c = 4'h0;
      7'b1001111: seg_val_c = 4'h1;
      7'b0010010: seg_val_c = 4'h2;
      7'b0000110: seg_val_c = 4'h3;
      7'b1001100: seg_val_c = 4'h4;
      7'b0100100: seg_val_c = 4'h5;
      7'b0100000: seg_val_c = 4'h6;
      7'b0001111: seg_val_c = 4'h7;
      7'b0000000: seg_val_c = 4'h8;
      7'b0000100: seg_val_c = 4'h9;
      7'b0001000: seg_val_c = 4'hA;
      7'b1100000: seg_val_c = 4'hB;
      7'b0110001: seg_val_c = 4'hC;
      7'b1000010: seg_val_c = 4'hD;
      7'b0110000: seg_val_c = 4'hE;
      7'b0111000: seg_val_c = 4'hF;
      default:    seg_legal_c = 1'b0;
    endcase
  end

  // Next-state for dwell counter, captured digits and frame tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    dp_d    = dp_q;
    valid_d = valid_q;
    err_d   = err_q;
    seen_d  = seen_q;
    fd_d    = 1'b0;

    if (!same_c) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Clear first so a capture landing in DONE counts toward the next frame.
    if (state_q == ST_DONE) begin
      seen_d = 4'h0;
    end

    if (capture_c && sel_ok_c) begin
      if (seg_legal_c) begin
        hex_d[{sel_idx_c, 2'b00} +: 4] = seg_val_c;
        dp_d[sel_idx_c]    = ~sseg_q[7];
        valid_d[sel_idx_c] = 1'b1;
        err_d[sel_idx_c]   = 1'b0;
        seen_d[sel_idx_c]  = 1'b1;
      end else begin
        valid_d[sel_idx_c] = 1'b0;
        err_d[sel_idx_c]   = 1'b1;
      end
    end

    unique case (state_q)
      ST_COLLECT: begin
        if (seen_d == 4'hF) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fd_d    = 1'b1;
        state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      hex_q   <= 16'h0000;
      dp_q    <= 4'h0;
      valid_q <= 4'h0;
      err_q   <= 4'h0;
      seen_q  <= 4'h0;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      fd_q    <= fd_d;
    end
  end

  assign hex_out    = hex_q;
  assign dp_out     = dp_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_to_hex.sv
// Bench for sseg_to_hex: directed vector table, hand-written dwell/reset sequences,
// and random scanning checked every cycle against a sample-history reference model.
module tb_sseg_to_hex;

  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int fd_count = 0;

  always #5 clk = ~clk;

  sseg_to_hex #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .sseg(sseg),
    .hex_out(hex_out), .dp_out(dp_out), .valid(valid), .err(err),
    .frame_done(frame_done)
  );

  // Segment glyphs (abcdefg, active low) indexed by hex value.
  logic [6:0] seg_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state.
  logic [3:0]  m_an_prev;
  logic [7:0]  m_sseg_prev;
  int          m_streak;
  logic [15:0] m_hex;
  logic [3:0]  m_dp, m_valid, m_err, m_seen;
  logic        m_fd, m_fd_pending;

  function automatic int decode_seg(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (seg_tbl[k] == p) return k;
    return -1;
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    int n = 0;
    int d = -1;
    for (int k = 0; k < 4; k++) if (!a[k]) begin n++; d = k; end
    return (n == 1) ? d : -1;
  endfunction

  task automatic model_reset();
    m_an_prev = 4'hF; m_sseg_prev = 8'hFF; m_streak = 0;
    m_hex = '0; m_dp = '0; m_valid = '0; m_err = '0; m_seen = '0;
    m_fd = 1'b0; m_fd_pending = 1'b0;
  endtask

  // One clock edge with inputs a/s sampled: a capture happens when the same
  // inputs have now been seen on S+1 consecutive edges (streak == S).
  task automatic model_edge(input logic [3:0] a, input logic [7:0] s);
    int d;
    int v;
    if (a == m_an_prev && s == m_sseg_prev) begin
      if (m_streak < 100000) m_streak++;
    end else begin
      m_streak = 0;
    end
    m_an_prev = a; m_sseg_prev = s;
    m_fd = m_fd_pending;
    m_fd_pending = 1'b0;
    if (m_fd) m_seen = 4'h0;
    if (m_streak == int'(S)) begin
      d = digit_of(a);
      if (d >= 0) begin
        v = decode_seg(s[6:0]);
        if (v >= 0) begin
          m_hex[4*d +: 4] = 4'(v);
          m_dp[d] = ~s[7];
          m_valid[d] = 1'b1;
          m_err[d] = 1'b0;
          m_seen[d] = 1'b1;
          if (!m_fd && m_seen == 4'hF) m_fd_pending = 1'b1;
        end else begin
          m_valid[d] = 1'b0;
          m_err[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_cycle();
    if (frame_done === 1'b1) fd_count++;
    cmp("cycle{hex,dp,valid,err,fd}",
        32'({hex_out, dp_out, valid, err, frame_done}),
        32'({m_hex, m_dp, m_valid, m_err, m_fd}));
  endtask

  // Called at a negedge; drives inputs, checks after the edge, returns at next negedge.
  task automatic step(input logic [3:0] a, input logic [7:0] s);
    an = a; sseg = s;
    @(posedge clk);
    model_edge(a, s);
    #1 check_cycle();
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) step(a, s);
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1 cmp("reset_async", 32'({hex_out, dp_out, valid, err, frame_done}), 32'h0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  sseg;
    int          hold;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic [3:0]  dp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{4'b1110, 8'h86, 8,  16'h0003, 4'b0001, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1101, 8'h92, 8,  16'h0023, 4'b0011, 4'b0000, 4'b0000};
    tbl[2] = '{4'b1011, 8'hCF, 8,  16'h0123, 4'b0111, 4'b0000, 4'b0000};
    tbl[3] = '{4'b0111, 8'h81, 8,  16'h0123, 4'b1111, 4'b0000, 4'b0000};
    tbl[4] = '{4'b1011, 8'hFF, 8,  16'h0123, 4'b1011, 4'b0100, 4'b0000};
    tbl[5] = '{4'b1011, 8'h38, 8,  16'h0F23, 4'b1111, 4'b0000, 4'b0100};
    tbl[6] = '{4'b1100, 8'h00, 20, 16'h0F23, 4'b1111, 4'b0000, 4'b0100};
    tbl[7] = '{4'b1111, 8'h00, 20, 16'h0F23, 4'b1111, 4'b0000, 4'b0100};

    an = 4'hF; sseg = 8'hFF; reset_n = 1'b1;
    do_reset();

    // Directed table: scan 0123, frame pulse, illegal then legal digit 2, ignored anodes.
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      hold(tbl[i].an, tbl[i].sseg, tbl[i].hold);
      cmp($sformatf("vec%0d_hex", i),   32'(hex_out), 32'(tbl[i].hex));
      cmp($sformatf("vec%0d_valid", i), 32'(valid),   32'(tbl[i].valid));
      cmp($sformatf("vec%0d_err", i),   32'(err),     32'(tbl[i].err));
      cmp($sformatf("vec%0d_dp", i),    32'(dp_out),  32'(tbl[i].dp));
      if (i == 3) cmp("frame_count_scan", 32'(fd_count), 32'd1);
    end
    cmp("frame_count_idle", 32'(fd_count), 32'd1);

    // Dwell one sample short, then exactly S+1 samples.
    hold(4'b1110, 8'h00, S);
    cmp("dwell_short", 32'(hex_out), 32'h0F23);
    step(4'b1111, 8'h00);
    hold(4'b1110, 8'h00, S);
    cmp("dwell_full_pre", 32'(hex_out), 32'h0F23);
    step(4'b1110, 8'h00);
    cmp("dwell_full_hex", 32'(hex_out), 32'h0F28);
    cmp("dwell_full_dp", 32'(dp_out), 32'h5);

    // Long hold: single capture, no frame without the other digits.
    do_reset();
    fd_count = 0;
    hold(4'b1101, 8'hA4, 100);
    cmp("long_hold_hex", 32'(hex_out), 32'h0050);
    cmp("long_hold_valid", 32'(valid), 32'h2);
    cmp("long_hold_frames", 32'(fd_count), 32'd0);

    // Reach seen=0111, reset mid-dwell of digit 3, then a frame needs all four again.
    hold(4'b1110, 8'hB0, 8);
    hold(4'b1011, 8'hA0, 8);
    cmp("midframe_hex", 32'(hex_out), 32'h065E);
    hold(4'b0111, 8'h8F, 2);
    do_reset();
    fd_count = 0;
    hold(4'b0111, 8'h8F, 8);
    cmp("post_reset_valid", 32'(valid), 32'h8);
    cmp("post_reset_frames", 32'(fd_count), 32'd0);
    hold(4'b1110, 8'hB0, 8);
    hold(4'b1101, 8'hA4, 8);
    hold(4'b1011, 8'hA0, 8);
    cmp("post_reset_hex", 32'(hex_out), 32'h765E);
    cmp("post_reset_frame_one", 32'(fd_count), 32'd1);

    // Random scanning with mixed legal/illegal patterns and dwell lengths.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] a;
      logic [7:0] s;
      logic [3:0] onehot_low;
      int n;
      onehot_low = 4'hF;
      onehot_low[$urandom_range(0, 3)] = 1'b0;
      a = ($urandom_range(0, 3) != 0) ? onehot_low : 4'($urandom);
      if ($urandom_range(0, 9) < 7) s = {1'($urandom_range(0, 1)), seg_tbl[$urandom_range(0, 15)]};
      else s = 8'($urandom);
      n = $urandom_range(1, 2 * S);
      hold(a, s, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
